// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared types, constants and helpers for the divided-clock checker.
//   state_t / ST_*  : checker FSM encoding (IDLE, HIGH, LOW)
//   DEF_CNT_W       : default width of the period and high-time counters
//   abs_diff        : unsigned absolute difference, used by the tolerance compare
package freq_div_pkg;

  localparam int DEF_CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_LOW  = 2'd2;

  // Operands are zero-extended by the caller, so the result never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

endpackage

// File: rtl/freq_div_edge_det.sv
// freq_div_edge_det: samples the divided clock in the clk domain and flags its edges.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   clk_div_in : divided clock under test
//   rise       : high for the cycle in which the sampled input has just gone 0->1
//   fall       : high for the cycle in which the sampled input has just gone 1->0
// Build option FREQ_DIV_CHK_SYNC_EN adds one extra sampling flop ahead of s, for
// inputs launched on the falling edge or from an unrelated clock.
module freq_div_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_div_in,
  output logic rise,
  output logic fall
);

  logic s;
  logic s_d;

`ifdef FREQ_DIV_CHK_SYNC_EN
  logic meta;

  // Two-flop sampling chain in front of the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= clk_div_in;
      s    <= meta;
    end
  end
`else
  // Single sampling flop in front of the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= 1'b0;
    end else begin
      s <= clk_div_in;
    end
  end
`endif

  // One-cycle history of the sampled input for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/freq_div_chk.sv
// freq_div_chk: measures period and high time of a divided clock in clk cycles,
// compares them against expected values, and reports sticky errors and lock.
//   clk         : system clock (same clock that drives the divider)
//   rst_n       : asynchronous active-low reset
//   clk_div_in  : divided clock under test
//   clr_err     : synchronous clear of period_err / duty_err
//   meas_period : last completed period measurement
//   meas_high   : last completed high-time measurement
//   meas_valid  : one-cycle pulse when a new measurement is latched
//   period_err  : sticky, period out of tolerance or input stuck (timeout)
//   duty_err    : sticky, high time out of tolerance
//   locked      : LOCK_NUM consecutive good periods seen
// Build option FREQ_DIV_CHK_SYNC_EN (see freq_div_edge_det) adds one cycle of
// sampling latency; measured values are unchanged for a stable input.
module freq_div_chk
  import freq_div_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int HIGH_NUM = 2,
  parameter int TOL      = 0,
  parameter int LOCK_NUM = 3,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             period_err,
  output logic             duty_err,
  output logic             locked
);

  localparam int GW = (LOCK_NUM < 1) ? 1 : $clog2(LOCK_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GW-1:0]    GOOD_ONE = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0]    LOCK_VAL = GW'(LOCK_NUM);

  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_nxt;
  logic             period_end;
  logic             timeout;
  logic [31:0]      per_diff;
  logic [31:0]      hi_diff;
  logic             per_bad;
  logic             hi_bad;
  logic [GW-1:0]    good_cnt;
  logic [GW-1:0]    good_nxt;

  freq_div_edge_det u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_div_in (clk_div_in),
    .rise       (rise),
    .fall       (fall)
  );

  // Next-state and counter update; a rise in LOW beats a coincident timeout.
  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    hi_nxt     = hi_cnt;
    period_end = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          per_nxt   = CNT_ONE;
          hi_nxt    = CNT_ONE;
          state_nxt = ST_HIGH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (per_cnt == CNT_MAX) begin
          timeout = 1'b1;
        end else if (fall) begin
          // The fall cycle is already low, so it only adds to the period.
          per_nxt   = per_cnt + CNT_ONE;
          state_nxt = ST_LOW;
        end else begin
          per_nxt = per_cnt + CNT_ONE;
          hi_nxt  = hi_cnt + CNT_ONE;
        end
      end
      ST_LOW: begin
        if (rise) begin
          period_end = 1'b1;
          per_nxt    = CNT_ONE;
          hi_nxt     = CNT_ONE;
          state_nxt  = ST_HIGH;
        end else if (per_cnt == CNT_MAX) begin
          timeout = 1'b1;
        end else begin
          per_nxt = per_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        per_nxt   = CNT_ZERO;
        hi_nxt    = CNT_ZERO;
      end
    endcase
    if (timeout) begin
      state_nxt = ST_IDLE;
      per_nxt   = CNT_ZERO;
      hi_nxt    = CNT_ZERO;
    end else begin
      state_nxt = state_nxt;
    end
  end

  assign per_diff = abs_diff(32'(per_cnt), 32'(CLK_DIV));
  assign hi_diff  = abs_diff(32'(hi_cnt), 32'(HIGH_NUM));
  assign per_bad  = per_diff > 32'(TOL);
  assign hi_bad   = hi_diff > 32'(TOL);
  assign good_nxt = (good_cnt == LOCK_VAL) ? good_cnt : good_cnt + GOOD_ONE;

  // FSM state and free-running period / high counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      per_cnt <= CNT_ZERO;
      hi_cnt  <= CNT_ZERO;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
    end
  end

  // Latch the completed measurement and pulse meas_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_period <= CNT_ZERO;
      meas_high   <= CNT_ZERO;
      meas_valid  <= 1'b0;
    end else begin
      meas_valid <= period_end;
      if (period_end) begin
        meas_period <= per_cnt;
        meas_high   <= hi_cnt;
      end
    end
  end

  // Consecutive-good-period counter and lock flag; any bad period or timeout unlocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= {GW{1'b0}};
      locked   <= 1'b0;
    end else if (timeout || (period_end && (per_bad || hi_bad))) begin
      good_cnt <= {GW{1'b0}};
      locked   <= 1'b0;
    end else if (period_end) begin
      good_cnt <= good_nxt;
      locked   <= (good_nxt == LOCK_VAL);
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_err <= 1'b0;
      duty_err   <= 1'b0;
    end else begin
      if (timeout || (period_end && per_bad)) begin
        period_err <= 1'b1;
      end else if (clr_err) begin
        period_err <= 1'b0;
      end
      if (period_end && hi_bad) begin
        duty_err <= 1'b1;
      end else if (clr_err) begin
        duty_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_div_chk.sv
// tb_freq_div_chk: directed test of freq_div_chk.
//   u_a : CLK_DIV=4, HIGH_NUM=2, TOL=0 (main checker)
//   u_b : CLK_DIV=5, HIGH_NUM=2, TOL=1 (tolerance boundaries, odd mode)
//   u_c : CLK_DIV=3, HIGH_NUM=1, TOL=1 (half-integer 2.5 pattern)
// All three watch the same clk_div_in. Inputs change and outputs are sampled on
// the falling edge of clk. Honors FREQ_DIV_CHK_SYNC_EN for the expected latency.
module tb_freq_div_chk;

`ifdef FREQ_DIV_CHK_SYNC_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif
  // Hold-low timeout: last rise at index 16, per_cnt hits 255 then trips one edge later.
  localparam int TO_IDX = 273 + (LAT - 6);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_div_in = 1'b0;
  logic clr_err = 1'b0;

  logic [7:0] a_period, a_high, b_period, b_high, c_period, c_high;
  logic a_valid, a_perr, a_derr, a_locked;
  logic b_valid, b_perr, b_derr, b_locked;
  logic c_valid, c_perr, c_derr, c_locked;

  int errors = 0;
  int checks = 0;

  int idx;
  int first_perr;
  int c_cnt;
  int c_oor;
  int mv_per[$];
  int mv_hi[$];
  int mv_lock[$];
  int mv_perr[$];
  int mv_idx[$];

  freq_div_chk u_a (
    .clk(clk), .rst_n(rst_n), .clk_div_in(clk_div_in), .clr_err(clr_err),
    .meas_period(a_period), .meas_high(a_high), .meas_valid(a_valid),
    .period_err(a_perr), .duty_err(a_derr), .locked(a_locked));

  freq_div_chk #(.CLK_DIV(5), .HIGH_NUM(2), .TOL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clk_div_in(clk_div_in), .clr_err(clr_err),
    .meas_period(b_period), .meas_high(b_high), .meas_valid(b_valid),
    .period_err(b_perr), .duty_err(b_derr), .locked(b_locked));

  freq_div_chk #(.CLK_DIV(3), .HIGH_NUM(1), .TOL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clk_div_in(clk_div_in), .clr_err(clr_err),
    .meas_period(c_period), .meas_high(c_high), .meas_valid(c_valid),
    .period_err(c_perr), .duty_err(c_derr), .locked(c_locked));

  always #5 clk = ~clk;

  // One clk cycle: record what the checkers show, then drive the next input value.
  task automatic step(input logic v);
    @(negedge clk);
    if (a_valid) begin
      mv_per.push_back(int'(a_period));
      mv_hi.push_back(int'(a_high));
      mv_lock.push_back(int'(a_locked));
      mv_perr.push_back(int'(a_perr));
      mv_idx.push_back(idx);
    end
    if (a_perr && first_perr < 0) first_perr = idx;
    if (c_valid) begin
      c_cnt++;
      if (c_period < 8'd2 || c_period > 8'd3 || c_high < 8'd1 || c_high > 8'd2) c_oor++;
    end
    clk_div_in = v;
    idx++;
  endtask

  task automatic start_run();
    mv_per.delete(); mv_hi.delete(); mv_lock.delete(); mv_perr.delete(); mv_idx.delete();
    idx = 0; first_perr = -1; c_cnt = 0; c_oor = 0;
  endtask

  task automatic run(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < per; c++) step(c < hi);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clk_div_in = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_period !== 8'd0) begin errors++; $display("FAIL reset_period got %0d want 0", a_period); end
    checks++; if (a_high !== 8'd0) begin errors++; $display("FAIL reset_high got %0d want 0", a_high); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", a_perr); end
    checks++; if (a_derr !== 1'b0) begin errors++; $display("FAIL reset_derr got %b want 0", a_derr); end
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", a_locked); end
  endtask

  task automatic test_even();
    do_reset(); start_run(); run(4, 2, 5);
    checks++; if (mv_per.size() !== 4) begin errors++; $display("FAIL even_count got %0d want 4", mv_per.size()); end
    for (int i = 0; i < mv_per.size(); i++) begin
      checks++; if (mv_per[i] !== 4) begin errors++; $display("FAIL even_period[%0d] got %0d want 4", i, mv_per[i]); end
      checks++; if (mv_hi[i] !== 2) begin errors++; $display("FAIL even_high[%0d] got %0d want 2", i, mv_hi[i]); end
      checks++; if (mv_lock[i] !== ((i >= 2) ? 1 : 0)) begin errors++; $display("FAIL even_lock[%0d] got %0d want %0d", i, mv_lock[i], (i >= 2) ? 1 : 0); end
    end
    if (mv_idx.size() > 0) begin
      checks++; if (mv_idx[0] !== LAT) begin errors++; $display("FAIL even_latency got %0d want %0d", mv_idx[0], LAT); end
    end
    checks++; if (a_perr !== 1'b0 || a_derr !== 1'b0) begin errors++; $display("FAIL even_errs got %b%b want 00", a_perr, a_derr); end
    checks++; if (b_perr !== 1'b0 || b_locked !== 1'b1) begin errors++; $display("FAIL even_b got perr=%b locked=%b want 0/1", b_perr, b_locked); end
  endtask

  task automatic test_odd();
    do_reset(); start_run(); run(5, 2, 5);
    checks++; if (mv_per.size() !== 4) begin errors++; $display("FAIL odd_count got %0d want 4", mv_per.size()); end
    for (int i = 0; i < mv_per.size(); i++) begin
      checks++; if (mv_per[i] !== 5 || mv_hi[i] !== 2) begin errors++; $display("FAIL odd_meas[%0d] got %0d/%0d want 5/2", i, mv_per[i], mv_hi[i]); end
    end
    checks++; if (b_perr !== 1'b0 || b_derr !== 1'b0 || b_locked !== 1'b1) begin errors++; $display("FAIL odd_b got perr=%b derr=%b locked=%b want 0/0/1", b_perr, b_derr, b_locked); end
    checks++; if (a_perr !== 1'b1 || a_derr !== 1'b0 || a_locked !== 1'b0) begin errors++; $display("FAIL odd_a got perr=%b derr=%b locked=%b want 1/0/0", a_perr, a_derr, a_locked); end
  endtask

  task automatic test_wrong_div();
    do_reset(); start_run(); run(6, 2, 4);
    checks++; if (mv_per.size() !== 3) begin errors++; $display("FAIL div6_count got %0d want 3", mv_per.size()); end
    if (mv_per.size() > 0) begin
      checks++; if (mv_per[0] !== 6 || mv_perr[0] !== 1) begin errors++; $display("FAIL div6_first got per=%0d perr=%0d want 6/1", mv_per[0], mv_perr[0]); end
    end
    checks++; if (a_locked !== 1'b0 || a_derr !== 1'b0) begin errors++; $display("FAIL div6_a got locked=%b derr=%b want 0/0", a_locked, a_derr); end
    checks++; if (b_perr !== 1'b0) begin errors++; $display("FAIL div6_b_tol got perr=%b want 0", b_perr); end
    // clr_err pulse while the input is quietly low
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL clr_perr got %b want 0", a_perr); end
    checks++; if (a_period !== 8'd6) begin errors++; $display("FAIL clr_keeps_meas got %0d want 6", a_period); end
    // period stretched by the two extra low cycles: 6 + 2
    start_run(); run(6, 2, 1);
    checks++; if (mv_per.size() !== 1) begin errors++; $display("FAIL reerr_count got %0d want 1", mv_per.size()); end
    if (mv_per.size() > 0) begin
      checks++; if (mv_per[0] !== 8 || mv_perr[0] !== 1) begin errors++; $display("FAIL reerr got per=%0d perr=%0d want 8/1", mv_per[0], mv_perr[0]); end
    end
    // clr_err held high: error at each period end must still win
    clr_err = 1'b1;
    start_run(); run(6, 2, 3);
    clr_err = 1'b0;
    checks++; if (mv_perr.size() !== 3) begin errors++; $display("FAIL errwin_count got %0d want 3", mv_perr.size()); end
    for (int i = 0; i < mv_perr.size(); i++) begin
      checks++; if (mv_perr[i] !== 1) begin errors++; $display("FAIL errwin[%0d] got %0d want 1", i, mv_perr[i]); end
    end
  endtask

  task automatic test_tolerance();
    do_reset(); start_run(); run(7, 2, 4);
    checks++; if (b_perr !== 1'b1 || b_derr !== 1'b0 || b_locked !== 1'b0) begin errors++; $display("FAIL tol_per7 got perr=%b derr=%b locked=%b want 1/0/0", b_perr, b_derr, b_locked); end
    do_reset(); start_run(); run(5, 4, 4);
    checks++; if (b_perr !== 1'b0 || b_derr !== 1'b1) begin errors++; $display("FAIL tol_hi4 got perr=%b derr=%b want 0/1", b_perr, b_derr); end
    do_reset(); start_run(); run(5, 3, 4);
    checks++; if (b_perr !== 1'b0 || b_derr !== 1'b0 || b_locked !== 1'b1) begin errors++; $display("FAIL tol_hi3 got perr=%b derr=%b locked=%b want 0/0/1", b_perr, b_derr, b_locked); end
    checks++; if (a_perr !== 1'b1 || a_derr !== 1'b1) begin errors++; $display("FAIL tol_a_strict got perr=%b derr=%b want 1/1", a_perr, a_derr); end
  endtask

  task automatic test_timeout();
    do_reset(); start_run(); run(4, 2, 5);
    for (int i = 0; i < 300; i++) step(1'b0);
    checks++; if (mv_per.size() !== 4) begin errors++; $display("FAIL to_no_valid got %0d pulses want 4", mv_per.size()); end
    if (mv_lock.size() > 2) begin
      checks++; if (mv_lock[2] !== 1) begin errors++; $display("FAIL to_prelock got %0d want 1", mv_lock[2]); end
    end
    checks++; if (first_perr !== TO_IDX) begin errors++; $display("FAIL to_cycle got %0d want %0d", first_perr, TO_IDX); end
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL to_unlock got %b want 0", a_locked); end
    start_run(); run(4, 2, 5);
    checks++; if (mv_per.size() !== 4) begin errors++; $display("FAIL relock_count got %0d want 4", mv_per.size()); end
    if (mv_idx.size() > 0) begin
      checks++; if (mv_idx[0] !== LAT) begin errors++; $display("FAIL relock_first got %0d want %0d", mv_idx[0], LAT); end
    end
    for (int i = 0; i < mv_lock.size(); i++) begin
      checks++; if (mv_lock[i] !== ((i >= 2) ? 1 : 0)) begin errors++; $display("FAIL relock_lock[%0d] got %0d want %0d", i, mv_lock[i], (i >= 2) ? 1 : 0); end
    end
    checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", a_perr); end
  endtask

  task automatic test_half_int();
    do_reset(); start_run();
    for (int r = 0; r < 6; r++) begin
      step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    end
    checks++; if (c_cnt !== 10) begin errors++; $display("FAIL half_count got %0d want 10", c_cnt); end
    checks++; if (c_oor !== 0) begin errors++; $display("FAIL half_range got %0d out-of-range want 0", c_oor); end
    checks++; if (c_perr !== 1'b0 || c_derr !== 1'b0 || c_locked !== 1'b1) begin errors++; $display("FAIL half_flags got perr=%b derr=%b locked=%b want 0/0/1", c_perr, c_derr, c_locked); end
  endtask

  task automatic test_reset_mid();
    do_reset(); start_run(); run(4, 2, 5);
    step(1'b1); step(1'b1);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL mid_prelock got %b want 1", a_locked); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_period !== 8'd0 || a_high !== 8'd0 || a_valid !== 1'b0) begin errors++; $display("FAIL mid_meas got %0d/%0d/%b want 0/0/0", a_period, a_high, a_valid); end
    checks++; if (a_locked !== 1'b0 || a_perr !== 1'b0 || a_derr !== 1'b0) begin errors++; $display("FAIL mid_flags got %b/%b/%b want 0/0/0", a_locked, a_perr, a_derr); end
    clk_div_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(); run(4, 2, 5);
    checks++; if (mv_per.size() !== 4) begin errors++; $display("FAIL mid_count got %0d want 4", mv_per.size()); end
    if (mv_idx.size() > 0) begin
      checks++; if (mv_idx[0] !== LAT || mv_per[0] !== 4) begin errors++; $display("FAIL mid_first got idx=%0d per=%0d want %0d/4", mv_idx[0], mv_per[0], LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_wrong_div();
    test_tolerance();
    test_timeout();
    test_half_int();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
